// File: rtl/serdes_lvds_pkg.sv
// Shared constants and encodings for the LVDS serial link (symbol framing, FSM states, disparity).
package serdes_lvds_pkg;

  localparam int unsigned SYM_W = 10;
  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  localparam logic [SYM_W-1:0] FLAG_SYM = {1'b0, FLAG_BYTE, 1'b0};
  localparam logic [SYM_W-1:0] IDLE_SYM = '0;

  typedef enum logic {
    StHunt   = 1'b0,
    StLocked = 1'b1
  } state_e;

  typedef enum logic {
    RdNeg = 1'b0,
    RdPos = 1'b1
  } rd_e;

  // Running disparity after a sub-block of `width` bits carrying `ones` ones.
  function automatic rd_e rd_after(input rd_e rd_in, input int unsigned ones,
                                   input int unsigned width);
    if (2 * ones > width) return RdPos;
    if (2 * ones < width) return RdNeg;
    return rd_in;
  endfunction

endpackage

// File: rtl/decode_10b8b.sv
// Combinational 8b/10b data-symbol decoder with running-disparity check.
// sym bit order is {j,h,g,f,i,e,d,c,b,a}; K-codes are treated as errors.
module decode_10b8b
  import serdes_lvds_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  input  rd_e              disp_in,
  output logic [7:0]       data,
  output rd_e              disp_out,
  output logic             code_err
);

  logic [5:0]  c6;
  logic [3:0]  c4;
  logic [4:0]  x;
  logic [2:0]  y;
  logic        ok6;
  logic        ok4;
  logic        alt_neg_x;
  logic        alt_pos_x;
  logic        disp_err;
  int unsigned ones6;
  int unsigned ones4;
  rd_e         rd_mid;

  always_comb begin
    c6    = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
    c4    = {sym[6], sym[7], sym[8], sym[9]};
    ones6 = $countones(c6);
    ones4 = $countones(c4);

    x   = '0;
    ok6 = 1'b1;
    case (c6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              ok6 = 1'b0;
    endcase

    y   = '0;
    ok4 = 1'b1;
    case (c4)
      4'b1011, 4'b0100:                   y = 3'd0;
      4'b1001:                            y = 3'd1;
      4'b0101:                            y = 3'd2;
      4'b1100, 4'b0011:                   y = 3'd3;
      4'b1101, 4'b0010:                   y = 3'd4;
      4'b1010:                            y = 3'd5;
      4'b0110:                            y = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: y = 3'd7;
      default:                            ok4 = 1'b0;
    endcase

    rd_mid   = rd_after(disp_in, ones6, 6);
    disp_out = rd_after(rd_mid, ones4, 4);

    // D.x.7 must use the alternate form exactly where the primary would create a run of five.
    alt_neg_x = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
    alt_pos_x = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);

    disp_err = (ones6 == 4 && disp_in == RdPos) || (ones6 == 2 && disp_in == RdNeg) ||
               (c6 == 6'b111000 && disp_in == RdPos) || (c6 == 6'b000111 && disp_in == RdNeg) ||
               (ones4 == 3 && rd_mid == RdPos) || (ones4 == 1 && rd_mid == RdNeg) ||
               (c4 == 4'b1100 && rd_mid == RdPos) || (c4 == 4'b0011 && rd_mid == RdNeg);

    code_err = !ok6 || !ok4 || disp_err ||
               (c4 == 4'b0111 && !alt_neg_x) || (c4 == 4'b1000 && !alt_pos_x) ||
               (c4 == 4'b1110 && alt_neg_x) || (c4 == 4'b0001 && alt_pos_x);

    data = {y, x};
  end

endmodule

// File: rtl/deserializer_8b.sv
// LVDS receive path: flag hunt, 10-bit symbol alignment, 8b/10b decode and byte presentation.
module deserializer_8b
  import serdes_lvds_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       st_flag_o,
  output logic       code_err_o,
  output logic       locked_o
);

  localparam int unsigned ErrW = $clog2(ERR_LIMIT + 1);
  localparam logic [ErrW-1:0] ErrMax = ErrW'(ERR_LIMIT);

  state_e           state_q, state_d;
  logic [SYM_W-1:0] shreg_q, shreg_d, sym_next;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  rd_e              rd_q, rd_d;
  logic [ErrW-1:0]  err_cnt_q, err_cnt_d, err_inc;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             flag_q, flag_d;
  logic             cerr_q, cerr_d;
  logic             locked_q, locked_d;

  logic [7:0] dec_data;
  rd_e        dec_disp;
  logic       dec_err;

  decode_10b8b u_decode (
    .sym      (sym_next),
    .disp_in  (rd_q),
    .data     (dec_data),
    .disp_out (dec_disp),
    .code_err (dec_err)
  );

  always_comb begin
    sym_next  = {shreg_q[SYM_W-2:0], serial_i};
    shreg_d   = sym_next;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rd_d      = rd_q;
    err_cnt_d = err_cnt_q;
    err_inc   = err_cnt_q + 1'b1;
    data_d    = data_q;
    flag_d    = flag_q;
    valid_d   = 1'b0;
    cerr_d    = 1'b0;
    locked_d  = locked_q;

    unique case (state_q)
      StHunt: begin
        locked_d = 1'b0;
        if (sym_next == FLAG_SYM) begin
          state_d   = StLocked;
          bit_cnt_d = '0;
          valid_d   = 1'b1;
          flag_d    = 1'b1;
          data_d    = FLAG_BYTE;
          locked_d  = 1'b1;
          rd_d      = RdNeg;
          err_cnt_d = '0;
        end
      end
      StLocked: begin
        if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = '0;
          if (sym_next == FLAG_SYM) begin
            valid_d   = 1'b1;
            flag_d    = 1'b1;
            data_d    = FLAG_BYTE;
            err_cnt_d = '0;
          end else if (sym_next == IDLE_SYM) begin
            // Idle line between frames: neither data nor evidence of misalignment.
          end else if (!dec_err) begin
            valid_d   = 1'b1;
            flag_d    = 1'b0;
            data_d    = dec_data;
            rd_d      = dec_disp;
            err_cnt_d = '0;
          end else begin
            cerr_d = 1'b1;
            rd_d   = dec_disp;
            if (err_cnt_q != ErrMax) err_cnt_d = err_inc;
            if (err_inc == ErrMax) begin
              state_d  = StHunt;
              locked_d = 1'b0;
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StHunt;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rd_q      <= RdNeg;
      err_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      flag_q    <= 1'b0;
      cerr_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      rd_q      <= rd_d;
      err_cnt_q <= err_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      flag_q    <= flag_d;
      cerr_q    <= cerr_d;
      locked_q  <= locked_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign st_flag_o  = flag_q;
  assign code_err_o = cerr_q;
  assign locked_o   = locked_q;

endmodule
